// File: rtl/p_ring_ctrl_if.sv
// rtl/p_ring_ctrl_if.sv - loader/compute handshake bundle for the N-bank ring controller
interface p_ring_ctrl_if #(
    parameter int NUM_BANKS = 2,
    parameter int EN_W      = 2
);
    localparam int BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
    localparam int CW = $clog2(NUM_BANKS + 1);

    logic            run;
    logic            fill_fin;
    logic [EN_W-1:0] fill_en;
    logic            fill_last;
    logic            cmp_fin;
    logic [BW-1:0]   wr_bank;
    logic            wr_ready;
    logic [BW-1:0]   cmp_bank;
    logic            cmp_start;
    logic [EN_W-1:0] cmp_en;
    logic [CW-1:0]   occupancy;
    logic            job_done;
    logic            proto_err;

    modport master (
        output run, fill_fin, fill_en, fill_last, cmp_fin,
        input  wr_bank, wr_ready, cmp_bank, cmp_start, cmp_en,
               occupancy, job_done, proto_err
    );

    modport slave (
        input  run, fill_fin, fill_en, fill_last, cmp_fin,
        output wr_bank, wr_ready, cmp_bank, cmp_start, cmp_en,
               occupancy, job_done, proto_err
    );
endinterface

// File: rtl/p_ring_ctrl.sv
// rtl/p_ring_ctrl.sv - N-bank ring buffer selector between a source loader and a compute engine
module p_ring_ctrl #(
    parameter int NUM_BANKS = 2,
    parameter int EN_W      = 2
) (
    input  logic          clk,
    input  logic          rst,
    p_ring_ctrl_if.slave  bus
);
    localparam int BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
    localparam int CW = $clog2(NUM_BANKS + 1);

    logic [NUM_BANKS-1:0] full, full_n;
    logic [EN_W-1:0]      masks   [NUM_BANKS];
    logic [EN_W-1:0]      masks_n [NUM_BANKS];
    logic [BW-1:0]        wr_ptr, wr_ptr_n;
    logic [BW-1:0]        cmp_ptr, cmp_ptr_n;
    logic [CW-1:0]        occ, occ_n;
    logic                 last_seen, last_seen_n;
    logic                 job_done_q, job_done_n;
    logic                 proto_err_q, proto_err_n;

    logic wr_ready, cmp_start;
    logic fill_acc, fill_set, cmp_acc;

    function automatic logic [BW-1:0] advance(input logic [BW-1:0] p);
        if (p == BW'(NUM_BANKS - 1))
            return '0;
        return p + BW'(1);
    endfunction

    assign wr_ready  = ~full[wr_ptr];
    assign cmp_start = full[cmp_ptr];
    assign fill_acc  = bus.fill_fin & wr_ready;
    assign fill_set  = fill_acc & (bus.fill_en != '0);
    assign cmp_acc   = bus.cmp_fin & cmp_start;

    always_comb begin
        full_n      = full;
        masks_n     = masks;
        wr_ptr_n    = wr_ptr;
        cmp_ptr_n   = cmp_ptr;
        occ_n       = occ;
        last_seen_n = last_seen;
        job_done_n  = 1'b0;
        proto_err_n = proto_err_q;

        // An empty-mask fill leaves the bank EMPTY and the loader refills the same slot
        if (fill_set) begin
            full_n[wr_ptr]  = 1'b1;
            masks_n[wr_ptr] = bus.fill_en;
            wr_ptr_n        = advance(wr_ptr);
            occ_n           = occ_n + CW'(1);
        end

        if (cmp_acc) begin
            full_n[cmp_ptr]  = 1'b0;
            masks_n[cmp_ptr] = '0;
            cmp_ptr_n        = advance(cmp_ptr);
            occ_n            = occ_n - CW'(1);
        end

        if (fill_acc && bus.fill_last)
            last_seen_n = 1'b1;

        if (last_seen_n && (occ_n == '0)) begin
            job_done_n  = 1'b1;
            last_seen_n = 1'b0;
        end

        if ((bus.fill_fin && !wr_ready) || (bus.cmp_fin && !cmp_start))
            proto_err_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.run) begin
            full        <= '0;
            for (int i = 0; i < NUM_BANKS; i++)
                masks[i] <= '0;
            wr_ptr      <= '0;
            cmp_ptr     <= '0;
            occ         <= '0;
            last_seen   <= 1'b0;
            job_done_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            full        <= full_n;
            masks       <= masks_n;
            wr_ptr      <= wr_ptr_n;
            cmp_ptr     <= cmp_ptr_n;
            occ         <= occ_n;
            last_seen   <= last_seen_n;
            job_done_q  <= job_done_n;
            proto_err_q <= proto_err_n;
        end
    end

    assign bus.wr_bank   = wr_ptr;
    assign bus.wr_ready  = wr_ready;
    assign bus.cmp_bank  = cmp_ptr;
    assign bus.cmp_start = cmp_start;
    assign bus.cmp_en    = masks[cmp_ptr];
    assign bus.occupancy = occ;
    assign bus.job_done  = job_done_q;
    assign bus.proto_err = proto_err_q;
endmodule
